// File: rtl/axiline_pkg.sv
// Shared types and sizing helpers for the Axiline training datapath.
package axiline_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Worst-case dot-product width: product width plus growth from summing every element.
  function automatic int unsigned calc_acc_width(input int unsigned bitwidth,
                                                 input int unsigned num_lanes,
                                                 input int unsigned num_chunks);
    return 2 * bitwidth + clog2(num_lanes * num_chunks);
  endfunction

endpackage

// File: rtl/mult_adder_tree.sv
// Lane-wise signed multipliers (S1) feeding a registered reduction sum (S2).
// Valid, first and last flags travel alongside the data through both stages.
module mult_adder_tree
  import axiline_pkg::*;
#(
  parameter int unsigned bitwidth  = 8,
  parameter int unsigned num_lanes = 4,
  localparam int unsigned prod_width = 2 * bitwidth,
  localparam int unsigned sum_width  = 2 * bitwidth + clog2(num_lanes)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [num_lanes*bitwidth-1:0]  in_x,
  input  logic [num_lanes*bitwidth-1:0]  in_w,
  output logic                           sum_valid,
  output logic                           sum_first,
  output logic                           sum_last,
  output logic [sum_width-1:0]           sum
);

  logic signed [prod_width-1:0] prod_d [num_lanes];
  logic signed [prod_width-1:0] prod_q [num_lanes];
  logic                         s1_valid_d, s1_valid_q;
  logic                         s1_first_d, s1_first_q;
  logic                         s1_last_d,  s1_last_q;
  logic signed [sum_width-1:0]  sum_d, sum_q;
  logic                         s2_valid_d, s2_valid_q;
  logic                         s2_first_d, s2_first_q;
  logic                         s2_last_d,  s2_last_q;
  logic signed [sum_width-1:0]  tree_sum;

  // Products only load on a valid beat so idle lanes do not toggle.
  always_comb begin
    s1_valid_d = in_valid;
    s1_first_d = in_first;
    s1_last_d  = in_last;
    for (int i = 0; i < int'(num_lanes); i++) begin
      prod_d[i] = prod_q[i];
      if (in_valid) begin
        prod_d[i] = prod_width'($signed(in_x[i*bitwidth +: bitwidth])) *
                    prod_width'($signed(in_w[i*bitwidth +: bitwidth]));
      end
    end
  end

  // Reduction of sign-extended products; synthesis balances this into a tree.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < int'(num_lanes); i++) begin
      tree_sum = tree_sum + sum_width'(prod_q[i]);
    end
    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    sum_d      = s1_valid_q ? tree_sum : sum_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      sum_q      <= '0;
      for (int i = 0; i < int'(num_lanes); i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
      sum_q      <= sum_d;
      for (int i = 0; i < int'(num_lanes); i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign sum_valid = s2_valid_q;
  assign sum_first = s2_first_q;
  assign sum_last  = s2_last_q;
  assign sum       = sum_q;

endmodule

// File: rtl/inner_product_acc.sv
// Streaming signed inner-product accumulator: beats flow through the multiply/reduce
// pipeline, accumulate across a vector, and the result is offered over valid/ready.
module inner_product_acc
  import axiline_pkg::*;
#(
  parameter int unsigned bitwidth   = 8,
  parameter int unsigned num_lanes  = 4,
  parameter int unsigned num_chunks = 4,
  localparam int unsigned acc_width = calc_acc_width(bitwidth, num_lanes, num_chunks)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [num_lanes*bitwidth-1:0] in_x,
  input  logic [num_lanes*bitwidth-1:0] in_w,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [acc_width-1:0]          out_data
);

  localparam int unsigned sum_width = 2 * bitwidth + clog2(num_lanes);
  localparam int unsigned cnt_width = (clog2(num_chunks) > 0) ? clog2(num_chunks) : 1;
  localparam logic [cnt_width-1:0] last_beat = cnt_width'(num_chunks - 1);

  acc_state_e                  state_d, state_q;
  logic [cnt_width-1:0]        cnt_d, cnt_q;
  logic signed [acc_width-1:0] acc_d, acc_q;
  logic                        s3_valid_d, s3_valid_q;
  logic                        s3_last_d,  s3_last_q;
  logic                        in_ready_d, in_ready_q;
  logic                        out_valid_d, out_valid_q;

  logic                        accept_c;
  logic                        beat_first_c;
  logic                        beat_last_c;
  logic                        sum_valid;
  logic                        sum_first;
  logic                        sum_last;
  logic [sum_width-1:0]        sum;
  logic signed [acc_width-1:0] sum_ext;

  assign accept_c     = in_valid && in_ready_q;
  assign beat_first_c = (cnt_q == '0);
  assign beat_last_c  = (cnt_q == last_beat);
  assign sum_ext      = acc_width'($signed(sum));

  mult_adder_tree #(
    .bitwidth  (bitwidth),
    .num_lanes (num_lanes)
  ) u_mult_adder_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_c),
    .in_first  (beat_first_c),
    .in_last   (beat_last_c),
    .in_x      (in_x),
    .in_w      (in_w),
    .sum_valid (sum_valid),
    .sum_first (sum_first),
    .sum_last  (sum_last),
    .sum       (sum)
  );

  // Beat counter, S3 accumulate and vector-level FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    s3_valid_d = sum_valid;
    s3_last_d  = sum_valid && sum_last;

    if (accept_c) begin
      cnt_d = beat_last_c ? '0 : cnt_q + cnt_width'(1);
    end

    if (sum_valid) begin
      acc_d = sum_first ? sum_ext : acc_q + sum_ext;
    end

    case (state_q)
      ST_ACC: begin
        if (accept_c && beat_last_c) state_d = ST_DRAIN;
      end
      // acc_q already holds the final sum once the last beat's S3 flag is seen.
      ST_DRAIN: begin
        if (s3_valid_q && s3_last_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase

    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_inner_product_acc.sv
// Bench for inner_product_acc: directed vectors with literal results plus random
// vectors, all checked every cycle against a vector-level dot-product model.
module tb_inner_product_acc;

  localparam int NL = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_w = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;

  int n_checks = 0;
  int n_err    = 0;

  inner_product_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int dot(input logic [31:0] x, input logic [31:0] w);
    int  s;
    byte xb;
    byte wb;
    s = 0;
    for (int l = 0; l < NL; l++) begin
      xb = x[8*l +: 8];
      wb = w[8*l +: 8];
      s  = s + int'(xb) * int'(wb);
    end
    return s;
  endfunction

  // Vector-level model: sums beats as they are accepted, expects the result 3 edges later.
  int cyc = 0;
  int ready_at = 0;
  int beats = 0;
  int partial = 0;
  int exp_val = 0;
  bit pending = 0;
  bit was_rst = 0;
  bit started = 0;

  always @(posedge clk) begin : model
    int nb;
    int np;
    bit npend;
    nb    = beats;
    np    = partial;
    npend = pending;
    if (!rst) begin
      started <= 1'b1;
      was_rst <= 1'b1;
      pending <= 1'b0;
      beats   <= 0;
      partial <= 0;
    end else begin
      was_rst <= 1'b0;
      cyc     <= cyc + 1;
      if (out_valid && out_ready) npend = 1'b0;
      if (in_valid && in_ready) begin
        np = np + dot(in_x, in_w);
        nb = nb + 1;
        if (nb == NC) begin
          exp_val  <= np;
          npend     = 1'b1;
          ready_at <= cyc + 1 + 3;
          nb        = 0;
          np        = 0;
        end
      end
      beats   <= nb;
      partial <= np;
      pending <= npend;
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      check("in_ready", longint'(in_ready), was_rst ? 0 : longint'(!pending));
      check("out_valid", longint'(out_valid),
            longint'(!was_rst && pending && (cyc >= ready_at)));
      if (was_rst) check("out_data_rst", longint'($signed(out_data)), 0);
      else if (out_valid) check("out_data", longint'($signed(out_data)), longint'(exp_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] x, input logic [31:0] w);
    int g;
    g = 0;
    in_x = x;
    in_w = w;
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [31:0] x, input logic [31:0] w, input bit gaps);
    for (int b = 0; b < NC; b++) begin
      send_beat(x, w);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // Waits for out_valid, pins data and model to a literal, then completes the handshake if out_ready.
  task automatic wait_result(input string name, input int exp, output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      tick();
      edges++;
    end
    check({name, "_valid"}, longint'(out_valid), 1);
    check(name, longint'($signed(out_data)), longint'(exp));
    check({name, "_model"}, longint'(exp_val), longint'(exp));
    if (out_ready) tick();
  endtask

  task automatic drain_random();
    int  g;
    bit  done;
    g = 0;
    done = 0;
    while (!done && g < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) done = 1;
      tick();
      g++;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] ones, m128, p127, twos, threes, fives, xv, wv;
    int n;
    ones   = pack4(1, 1, 1, 1);
    m128   = pack4(-128, -128, -128, -128);
    p127   = pack4(127, 127, 127, 127);
    twos   = pack4(2, 2, 2, 2);
    threes = pack4(3, 3, 3, 3);
    fives  = pack4(5, 5, 5, 5);
    xv     = pack4(1, 2, 3, 4);
    wv     = pack4(4, 3, 2, 1);

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'($signed(out_data)), 0);
    rst = 1'b1;
    tick();
    check("release_in_ready", longint'(in_ready), 1);

    // All ones, latency and in_ready timing
    out_ready = 1'b1;
    send_vec(ones, ones, 1'b0);
    check("drain_in_ready", longint'(in_ready), 0);
    wait_result("ones", 16, n);
    check("latency_edges", longint'(n), 3);
    check("post_hs_in_ready", longint'(in_ready), 1);
    check("post_hs_out_valid", longint'(out_valid), 0);

    // Sign extremes
    send_vec(m128, m128, 1'b0);
    wait_result("neg_neg", 262144, n);
    send_vec(m128, p127, 1'b0);
    wait_result("neg_pos", -260096, n);

    // Bubble pattern 1,0,1,0,0,1,1
    send_beat(ones, ones);
    tick();
    send_beat(ones, ones);
    repeat (2) tick();
    send_beat(ones, ones);
    send_beat(ones, ones);
    wait_result("bubbles", 16, n);

    // Backpressure hold
    out_ready = 1'b0;
    send_vec(twos, threes, 1'b0);
    wait_result("hold", 96, n);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", longint'(out_valid), 1);
      check("hold_data", longint'($signed(out_data)), 96);
      check("hold_in_ready", longint'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("hold_release_in_ready", longint'(in_ready), 1);
    check("hold_release_valid", longint'(out_valid), 0);

    // Mid-vector reset discards the partial sum
    send_beat(fives, fives);
    send_beat(fives, fives);
    rst = 1'b0;
    tick();
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    rst = 1'b1;
    tick();
    check("midrst_release", longint'(in_ready), 1);
    send_vec(twos, threes, 1'b0);
    wait_result("after_rst", 96, n);

    // Back-to-back vectors
    send_vec(ones, ones, 1'b0);
    wait_result("b2b_ones", 16, n);
    send_vec(xv, wv, 1'b0);
    wait_result("b2b_lanes", 80, n);

    // Random vectors with random bubbles and backpressure
    for (int v = 0; v < 25; v++) begin
      for (int b = 0; b < NC; b++) begin
        send_beat($urandom, $urandom);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain_random();
    end
    out_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/inner_product_acc.md
Name: inner_product_acc

Overview:
- Streaming signed inner-product accumulator for the Axiline training datapath.
- Consumes a vector of x (sample features) and w (weights) delivered as num_chunks beats of num_lanes elements each.
- Per beat: multiplies lane-wise, reduces through an adder tree, and accumulates across beats.
- Presents the full dot product to the downstream gradient/update stage over a valid/ready handshake.

Parameters:
- bitwidth, 8, width of each signed two's-complement x/w element.
- num_lanes, 4, elements per beat; power of two, >=1.
- num_chunks, 4, beats per vector; >=1.
- acc_width, localparam = 2*bitwidth + clog2(num_lanes*num_chunks), result width; never overflows.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (asserted when 0)
- in_valid  in  1  beat present on in_x/in_w
- in_ready  out  1  block accepts a beat this cycle
- in_x  in  num_lanes*bitwidth  packed signed elements, lane 0 in LSBs
- in_w  in  num_lanes*bitwidth  packed signed weights, lane 0 in LSBs
- out_valid  out  1  out_data holds a completed dot product
- out_ready  in  1  downstream accepts out_data
- out_data  out  acc_width  signed dot product

Behaviour:
- Beat accepted on a rising edge with in_valid && in_ready. in_valid low mid-vector is a bubble: beat counter holds, nothing accumulates.
- Pipeline (each stage carries a valid bit and a "first" flag):
  - S1 registers num_lanes signed products (2*bitwidth each).
  - S2 registers the sign-extended adder-tree sum.
  - S3 updates acc: acc <= sum when first, else acc + sum.
- All arithmetic is signed, sign-extended to acc_width before adding. No saturation is needed: acc_width is sized for the worst case.
- Beat counter: 0..num_chunks-1, increments per accepted beat, wraps to 0 after the last beat. A beat is "first" when the counter is 0 and "last" when it is num_chunks-1.
- FSM:
  - ACC: in_ready=1, out_valid=0. Accepting the last beat -> DRAIN.
  - DRAIN: in_ready=0. Waits until S3 consumes the last beat -> DONE.
  - DONE: in_ready=0, out_valid=1, out_data=acc. On out_valid && out_ready -> ACC.
- Latency: out_valid rises 3 rising edges after the edge that accepted the last beat. in_ready returns to 1 on the edge after the output handshake.
- While out_valid=1 && out_ready=0, out_data and out_valid are held stable.
- num_chunks=1: every beat is both first and last.
- Reset (rst=0 at an edge) is allowed mid-vector:
  - state <- ACC, counter <- 0, all stage valids <- 0, acc <- 0.
  - out_valid <- 0, out_data <- 0, in_ready <- 0 during reset, 1 on the first cycle after release.
  - The partial vector is discarded; the next accepted beat is treated as first.
- out_data is driven from acc (0 after reset); it is meaningful only while out_valid=1.

Decomposition:
- Shared package axiline_pkg:
  - FSM state enum (ST_ACC, ST_DRAIN, ST_DONE).
  - clog2 function.
  - Function computing acc_width from bitwidth/num_lanes/num_chunks.
- One sub-module, mult_adder_tree (params bitwidth, num_lanes): lane multipliers plus registered adder tree, implementing S1/S2 with valid/first passthrough.
- Counter, FSM and accumulator stay in the top module.

Test Plan:
- All x=1, w=1, 4 consecutive beats, out_ready=1 -> out_data=16; out_valid high exactly 3 edges after the 4th accept; in_ready low from the edge after the 4th accept until one edge after the handshake.
- x=-128, w=-128 all lanes, 4 beats -> out_data=262144. Then x=-128, w=127 -> out_data=-260096 (sign extension across 20 bits).
- Same all-ones vector with in_valid 1,0,1,0,0,1,1 over 7 cycles (4 beats total) -> out_data=16; counter advances only on accepted beats.
- Vector x=2, w=3 with out_ready=0 for 5 cycles after out_valid -> out_data=96 stable, out_valid=1, in_ready=0 throughout. Raise out_ready -> handshake, then in_ready=1 next cycle.
- Accept 2 beats of x=5, w=5, assert rst=0 for 1 cycle -> out_valid=0, counter=0. Then a full vector x=2, w=3 -> out_data=96, not polluted by 200.
- Back-to-back vectors (ones, then lane-varying x={1,2,3,4}, w={4,3,2,1} for all 4 beats), out_ready tied 1 -> out_data 16 then 80, no lost or duplicated results.
